// File: rtl/sobel_ctrl_pkg.sv
// Shared types and defaults for the Sobel pipeline controller: FSM state
// encoding, per-frame measurement result and saturating counter helper.
package sobel_ctrl_pkg;

  localparam int CNT_W        = 12;
  localparam int DEF_MIN_LINES = 3;
  localparam int DEF_THR      = 400;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    MEAS = 2'd1,
    RUN  = 2'd2,
    BYP  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] lines;
    logic             mismatch;
    logic             sat;
  } frame_res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sobel_ctrl_meas.sv
// Measures active line width and line count of each frame from vsync/de and
// reports the result with a one-cycle frame_done pulse on every vsync rise.
module sobel_ctrl_meas
  import sobel_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       de,
  output logic       frame_done,
  output frame_res_t frame_res
);

  logic             vsync_q;
  logic             de_q;
  logic             line_open;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] ref_w;
  logic             mismatch;
  logic             sat;

  logic             vr;
  logic             df;
  logic             dr;
  logic             close_vr;
  logic             close_line;
  logic             first_line;
  logic [CNT_W-1:0] pix_now;
  logic [CNT_W-1:0] close_w;
  logic [CNT_W-1:0] lines_inc;
  frame_res_t       upd;

  // A line still open at vsync rise is closed with the count including that
  // cycle; line_open then drops so the trailing de fall is not a second line.
  always_comb begin
    vr         = vsync & ~vsync_q;
    df         = ~de & de_q;
    dr         = de & ~de_q;
    pix_now    = dr ? CNT_W'(1) : sat_inc(pix_cnt);
    close_vr   = vr & de & (line_open | dr);
    close_line = (df & line_open) | close_vr;
    close_w    = close_vr ? pix_now : pix_cnt;
    lines_inc  = sat_inc(line_cnt);
    first_line = (line_cnt == '0);

    upd.width    = ref_w;
    upd.lines    = line_cnt;
    upd.mismatch = mismatch;
    upd.sat      = sat;
    if (close_line) begin
      upd.width    = first_line ? close_w : ref_w;
      upd.lines    = lines_inc;
      upd.mismatch = mismatch | (!first_line && (close_w != ref_w));
      upd.sat      = sat | (close_w == CNT_MAX) | (lines_inc == CNT_MAX);
    end
  end

  assign frame_done = vr;
  assign frame_res  = upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      line_open <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      ref_w     <= '0;
      mismatch  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      vsync_q <= vsync;
      de_q    <= de;
      if (de) begin
        pix_cnt <= pix_now;
      end
      if (vr || df) begin
        line_open <= 1'b0;
      end else if (dr) begin
        line_open <= 1'b1;
      end
      if (vr) begin
        line_cnt <= '0;
        ref_w    <= '0;
        mismatch <= 1'b0;
        sat      <= 1'b0;
      end else if (close_line) begin
        line_cnt <= upd.lines;
        ref_w    <= upd.width;
        mismatch <= upd.mismatch;
        sat      <= upd.sat;
      end
    end
  end

endmodule

// File: rtl/sobel_ctrl.sv
// Frame-synchronous Sobel controller: validates the measured format and applies
// mode/threshold at frame boundaries. Optional watchdog: SOBEL_CTRL_TIMEOUT_EN.
module sobel_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int MAX_LINE_WIDTH = 2100,
  parameter int THR_W          = 11,
  parameter int THR_DEFAULT    = sobel_ctrl_pkg::DEF_THR,
  parameter int MIN_LINES      = sobel_ctrl_pkg::DEF_MIN_LINES,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic             en_req,
  input  logic [THR_W-1:0] thr_req,
  output logic             sobel_sel,
  output logic [THR_W-1:0] thr_out,
  output logic [CNT_W-1:0] line_width,
  output logic [CNT_W-1:0] frame_lines,
  output logic             fmt_err,
  output logic [1:0]       state
);

  ctrl_state_e      state_q, state_d;
  logic             sel_q, sel_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic             err_q, err_d;

  logic             frame_done;
  frame_res_t       frame_res;
  logic             frame_valid;
  logic             same_fmt;
  logic             timeout;

  // hsync only qualifies debug views of the timing; nothing here depends on it.
  logic unused_hsync;
  assign unused_hsync = hsync;

  sobel_ctrl_meas u_meas (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .de         (de),
    .frame_done (frame_done),
    .frame_res  (frame_res)
  );

  assign frame_valid = (frame_res.width != '0)
                     && (frame_res.width <= CNT_W'(MAX_LINE_WIDTH))
                     && (frame_res.lines >= CNT_W'(MIN_LINES))
                     && !frame_res.mismatch
                     && !frame_res.sat;
  assign same_fmt = (frame_res.width == width_q) && (frame_res.lines == lines_q);

`ifdef SOBEL_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts cycles since the last vsync rise, so it holds TIMEOUT_CYCLES in the
  // last cycle before the forced return to SYNC.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (frame_done) begin
      to_cnt_d = TO_W'(1);
    end else if (state_q == SYNC) begin
      to_cnt_d = '0;
    end else if (!timeout) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q != SYNC) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    thr_d   = thr_q;
    width_d = width_q;
    lines_d = lines_q;
    err_d   = err_q;
    if (frame_done) begin
      case (state_q)
        SYNC: state_d = MEAS;
        MEAS: begin
          if (!frame_valid) begin
            err_d = 1'b1;
          end else begin
            width_d = frame_res.width;
            lines_d = frame_res.lines;
            err_d   = 1'b0;
            thr_d   = thr_req;
            state_d = en_req ? RUN : BYP;
            sel_d   = en_req;
          end
        end
        RUN, BYP: begin
          if (frame_valid && same_fmt) begin
            thr_d   = thr_req;
            state_d = en_req ? RUN : BYP;
            sel_d   = en_req;
          end else begin
            state_d = MEAS;
            sel_d   = 1'b0;
            if (!frame_valid) begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end else if (timeout) begin
      state_d = SYNC;
      sel_d   = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      sel_q   <= 1'b0;
      thr_q   <= THR_W'(THR_DEFAULT);
      width_q <= '0;
      lines_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      thr_q   <= thr_d;
      width_q <= width_d;
      lines_q <= lines_d;
      err_q   <= err_d;
    end
  end

  assign sobel_sel   = sel_q;
  assign thr_out     = thr_q;
  assign line_width  = width_q;
  assign frame_lines = lines_q;
  assign fmt_err     = err_q;
  assign state       = state_q;

endmodule
